mem_responder: RTL and testbench

//  Memory-side responder for the control unit's MOV/MOC bus. It accepts one read or write
//  per handshake, waits LATENCY cycles, performs a big-endian byte/halfword/word access to
//  an internal byte array, then returns MOC. It sits between the MAR/MDR datapath and the
//  CPU's main memory.

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the MOV/MOC memory bus.
// Used by the responder and by the control unit.
package mem_responder_pkg;

    localparam logic [1:0] TD_BYTE = 2'b00;
    localparam logic [1:0] TD_HALF = 2'b01;
    localparam logic [1:0] TD_WORD = 2'b10;
    localparam logic [1:0] TD_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering and fault detection.
// Byte lane 3 is the byte at the access address.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [1:0]  td,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_bytes,
    input  logic [31:0] din,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    always_comb begin
        fault = 1'b0;
        rdata = '0;
        be    = '0;
        wdata = '0;
        unique case (1'b1)
            (td == TD_BYTE): begin
                rdata = {24'b0, rd_bytes[31:24]};
                be    = 4'b1000;
                wdata = {din[7:0], 24'b0};
            end
            (td == TD_HALF): begin
                fault = addr_lo[0];
                rdata = {16'b0, rd_bytes[31:16]};
                be    = 4'b1100;
                wdata = {din[15:0], 16'b0};
            end
            (td == TD_WORD): begin
                fault = (addr_lo != 2'b00);
                rdata = rd_bytes;
                be    = 4'b1111;
                wdata = din;
            end
            default: fault = 1'b1;
        endcase
        if (fault) begin
            rdata = '0;
            be    = '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one MOV request,
// waits LATENCY cycles, accesses the byte array, raises MOC.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        typeData,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              ERR
);

    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    logic [7:0]        mem [0:2**ADDR_W-1];
    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              rw_q;
    logic [1:0]        td_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic              err_q;

    logic              idle;
    logic              enter_done;
    logic              s_rw;
    logic [1:0]        s_td;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       s_din;
    logic [31:0]       rd_bytes;
    logic              fault;
    logic [31:0]       rdata;
    logic [3:0]        be;
    logic [31:0]       wdata;

    // With zero latency the access happens on the capture edge,
    // so the live inputs stand in for the not-yet-captured copy.
    always_comb begin
        idle  = (state == ST_IDLE);
        s_rw  = idle ? RW       : rw_q;
        s_td  = idle ? typeData : td_q;
        a0    = idle ? Address  : addr_q;
        s_din = idle ? DataIn   : din_q;
        a1    = a0 + ADDR_W'(1);
        a2    = a0 + ADDR_W'(2);
        a3    = a0 + ADDR_W'(3);
        enter_done = (idle && MOV && (LATENCY == 0))
                   || ((state == ST_WAIT) && (cnt == '0));
        rd_bytes = {mem[a0], mem[a1], mem[a2], mem[a3]};
    end

    mem_lane_align u_align (
        .td       (s_td),
        .addr_lo  (a0[1:0]),
        .rd_bytes (rd_bytes),
        .din      (s_din),
        .fault    (fault),
        .rdata    (rdata),
        .be       (be),
        .wdata    (wdata)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rw_q    <= RW_READ;
            td_q    <= TD_BYTE;
            addr_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            DataOut <= '0;
        end else begin
            if (enter_done) begin
                err_q <= fault;
                if (s_rw == RW_READ)
                    DataOut <= rdata;
            end
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (MOV) begin
                        rw_q   <= RW;
                        td_q   <= typeData;
                        addr_q <= Address;
                        din_q  <= DataIn;
                        if (LATENCY > 0) begin
                            cnt   <= CW'(LATENCY - 1);
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                (state == ST_WAIT): begin
                    if (cnt == '0)
                        state <= ST_DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                (state == ST_DONE): begin
                    if (!MOV)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by CLR so a reset edge never commits a write.
    always_ff @(posedge CLK) begin
        if (CLR && enter_done && (s_rw == RW_WRITE)) begin
            if (be[3]) mem[a0] <= wdata[31:24];
            if (be[2]) mem[a1] <= wdata[23:16];
            if (be[1]) mem[a2] <= wdata[15:8];
            if (be[0]) mem[a3] <= wdata[7:0];
        end
    end

    assign MOC = (state == ST_DONE);
    assign ERR = MOC & err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: LATENCY=2 and LATENCY=0 responders.
// Shared inputs, separate MOV lines.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        mov2, mov0;
    logic        RW;
    logic [1:0]  td;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout2, dout0;
    logic        moc2, moc0, err2, err0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (
        .CLK(CLK), .CLR(CLR), .MOV(mov2), .RW(RW),
        .typeData(td), .Address(addr), .DataIn(din),
        .DataOut(dout2), .MOC(moc2), .ERR(err2)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
        .CLK(CLK), .CLR(CLR), .MOV(mov0), .RW(RW),
        .typeData(td), .Address(addr), .DataIn(din),
        .DataOut(dout0), .MOC(moc0), .ERR(err0)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One handshake; inputs are scrambled after the
    // sampling edge to prove only the captured copy counts.
    task automatic op(input bit z, input logic rw,
                      input logic [1:0] t,
                      input logic [7:0] a,
                      input logic [31:0] d,
                      output logic [31:0] dv,
                      output logic e,
                      output int n,
                      output logic moc_after);
        RW = rw; td = t; addr = a; din = d;
        if (z) mov0 = 1'b1; else mov2 = 1'b1;
        n = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            n++;
            if ((z ? moc0 : moc2) === 1'b1) break;
            addr = ~a; din = ~d; RW = ~rw;
        end
        dv = z ? dout0 : dout2;
        e  = z ? err0 : err2;
        mov0 = 1'b0; mov2 = 1'b0;
        @(posedge CLK); #1;
        moc_after = z ? moc0 : moc2;
        @(negedge CLK);
    endtask

    task automatic run_basic(input bit z, input int lat,
                             input string p);
        logic [31:0] dv;
        logic e, ma;
        int n;
        op(z, RW_WRITE, TD_WORD, 8'h04, 32'hDEADBEEF,
           dv, e, n, ma);
        chk({p, "wr_lat"}, 32'(n), 32'(lat + 1));
        chk({p, "wr_err"}, {31'b0, e}, 32'd0);
        chk({p, "wr_mocl"}, {31'b0, ma}, 32'd0);
        op(z, RW_READ, TD_WORD, 8'h04, 32'h0, dv, e, n, ma);
        chk({p, "rd_lat"}, 32'(n), 32'(lat + 1));
        chk({p, "rdw04"}, dv, 32'hDEADBEEF);
        op(z, RW_READ, TD_BYTE, 8'h05, 32'h0, dv, e, n, ma);
        chk({p, "rdb05"}, dv, 32'h000000AD);
        op(z, RW_READ, TD_HALF, 8'h06, 32'h0, dv, e, n, ma);
        chk({p, "rdh06"}, dv, 32'h0000BEEF);
        op(z, RW_WRITE, TD_BYTE, 8'h07, 32'hFFFFFF11,
           dv, e, n, ma);
        op(z, RW_READ, TD_WORD, 8'h04, 32'h0, dv, e, n, ma);
        chk({p, "rdw04b"}, dv, 32'hDEADBE11);
    endtask

    initial begin
        logic [31:0] dv;
        logic e, ma, seen;
        int n;

        CLR = 1'b0; mov2 = 1'b1; mov0 = 1'b1;
        RW = RW_READ; td = TD_WORD;
        addr = 8'h00; din = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_moc2", {31'b0, moc2}, 32'd0);
        chk("rst_err2", {31'b0, err2}, 32'd0);
        chk("rst_dout2", dout2, 32'd0);
        chk("rst_moc0", {31'b0, moc0}, 32'd0);
        chk("rst_dout0", dout0, 32'd0);
        @(negedge CLK);
        mov2 = 1'b0; mov0 = 1'b0; CLR = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (moc2 || moc0) seen = 1'b1;
        end
        chk("idle_nomoc", {31'b0, seen}, 32'd0);
        @(negedge CLK);

        run_basic(1'b0, 2, "l2_");

        op(1'b0, RW_READ, TD_WORD, 8'h02, 32'h0, dv, e, n, ma);
        chk("mis_err", {31'b0, e}, 32'd1);
        chk("mis_dout", dv, 32'd0);
        chk("mis_errclr", {31'b0, err2}, 32'd0);
        op(1'b0, RW_WRITE, TD_RSVD, 8'h04, 32'h12345678,
           dv, e, n, ma);
        chk("rsvd_err", {31'b0, e}, 32'd1);
        op(1'b0, RW_READ, TD_WORD, 8'h04, 32'h0, dv, e, n, ma);
        chk("rsvd_nowr", dv, 32'hDEADBE11);
        chk("rsvd_ok", {31'b0, e}, 32'd0);
        op(1'b0, RW_WRITE, TD_HALF, 8'h05, 32'h0000AAAA,
           dv, e, n, ma);
        chk("hmis_err", {31'b0, e}, 32'd1);
        op(1'b0, RW_READ, TD_WORD, 8'h04, 32'h0, dv, e, n, ma);
        chk("hmis_nowr", dv, 32'hDEADBE11);

        op(1'b0, RW_WRITE, TD_WORD, 8'hFC, 32'hA1B2C3D4,
           dv, e, n, ma);
        chk("top_err", {31'b0, e}, 32'd0);
        op(1'b0, RW_READ, TD_WORD, 8'hFC, 32'h0, dv, e, n, ma);
        chk("top_rdw", dv, 32'hA1B2C3D4);
        op(1'b0, RW_READ, TD_BYTE, 8'hFF, 32'h0, dv, e, n, ma);
        chk("top_rdb", dv, 32'h000000D4);

        op(1'b0, RW_WRITE, TD_WORD, 8'h08, 32'h01234567,
           dv, e, n, ma);
        op(1'b0, RW_READ, TD_WORD, 8'h08, 32'h0, dv, e, n, ma);
        chk("pre08", dv, 32'h01234567);
        RW = RW_WRITE; td = TD_WORD;
        addr = 8'h08; din = 32'hCAFEF00D;
        mov2 = 1'b1;
        @(posedge CLK); #1;
        mov2 = 1'b0;
        CLR = 1'b0;
        #2;
        chk("clr_dout", dout2, 32'd0);
        CLR = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (moc2) seen = 1'b1;
        end
        chk("clr_nomoc", {31'b0, seen}, 32'd0);
        @(negedge CLK);
        op(1'b0, RW_READ, TD_WORD, 8'h08, 32'h0, dv, e, n, ma);
        chk("clr_nowr", dv, 32'h01234567);

        run_basic(1'b1, 0, "l0_");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
